mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised memory-access stage for the pipelined core, successor to the combinational MEM stage. Sits between the EX/MEM pipeline register and MEM/WB. Adds sub-word loads/stores with byte strobes and sign/zero extension, misalignment detection, and a variable-latency request/ready data-memory handshake that stalls upstream while a transaction is outstanding. Non-memory instructions pass through with one cycle of latency.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- ADDR_W, 32, data-memory address width; must be ≤ XLEN.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- EX_MEM_valid  in  1  instruction present on the EX_MEM_* inputs.
- EX_MEM_memread, EX_MEM_memwrite, EX_MEM_memtoreg, EX_MEM_regwrite  in  1 each  control bits.
- EX_MEM_funct3  in  3  access size/signedness.
- EX_MEM_rd  in  5  destination register.
- EX_MEM_ALU_result  in  XLEN  effective address or ALU result.
- EX_MEM_rs2_data  in  XLEN  store data.
- MEM_stall  out  1  upstream must hold the EX_MEM_* inputs.
- mem_req  out  1  data-memory request.
- mem_we  out  1  write when 1.
- mem_addr  out  ADDR_W  address, aligned down to XLEN/8 bytes.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wstrb  out  XLEN/8  byte-enable strobes.
- mem_ready  in  1  memory completes the current request.
- mem_rdata  in  XLEN  full-word read data, valid when mem_ready=1.
- MEM_valid  out  1  one-cycle pulse when writeback fields are valid.
- MEM_regwrite, MEM_memtoreg  out  1 each  forwarded controls.
- MEM_rd  out  5  forwarded destination.
- MEM_ALU_result  out  XLEN  forwarded ALU result.
- MEM_load_data  out  XLEN  extended load result.
- MEM_fault  out  1  misaligned or illegal-size access.

## Operation
- States: IDLE, BUSY. MEM_stall = (state==BUSY). Inputs are sampled only in IDLE.
- Offset: off = EX_MEM_ALU_result[log2(XLEN/8)-1:0].
- funct3 semantics:
  - 000 LB/SB; 001 LH/SH; 010 LW/SW; 100 LBU; 101 LHU.
  - 011 LD/SD and 110 LWU are legal only when XLEN=64.
  - All other codes are illegal.
- Misaligned: a halfword with off[0]≠0, a word with off[1:0]≠0, or a doubleword with off≠0.
- IDLE, EX_MEM_valid=1, with neither memread nor memwrite: register the controls, rd and ALU_result. Next cycle: MEM_valid=1, MEM_fault=0, MEM_load_data=0. Stay in IDLE.
- IDLE, memory op, illegal or misaligned: no request is issued. Next cycle: MEM_valid=1, MEM_fault=1, MEM_regwrite=0, MEM_load_data=0.
- IDLE, memory op, legal and aligned: latch the request and go to BUSY.
  - mem_we = memwrite; memwrite takes precedence if both bits are set.
  - mem_addr = ALU_result[ADDR_W-1:0] with the low log2(XLEN/8) bits cleared.
  - mem_wdata = rs2_data << (8·off).
  - mem_wstrb = size mask (1, 3, F or FF) << off; all zero for loads.
- BUSY: mem_req=1 and the request outputs are held stable.
  - On mem_ready=1: extract = mem_rdata >> (8·off), truncate to the access size, sign-extend (LB, LH, LW on 64) or zero-extend (LBU, LHU, LWU).
  - Register the result to MEM_load_data; stores load 0.
  - Next cycle: MEM_valid=1, state returns to IDLE.
- mem_ready while in IDLE is ignored. mem_req never asserts in IDLE.

## Timing
- Reset (async, immediate): state=IDLE; every output is 0, including mem_req, mem_wstrb, MEM_valid and MEM_stall. An in-flight request is abandoned, and a mem_ready arriving after reset is ignored.
- Non-memory and faulting instructions: accepted in cycle T, MEM_valid in T+1.
- Memory access: accepted in T, mem_req high from T+1. With mem_ready first seen in cycle T+k (k≥1), MEM_valid pulses in T+k+1 and the next instruction is accepted in T+k+1.
- Back-to-back throughput is one memory op per k+1 cycles.
- MEM_valid is a single-cycle pulse; the MEM_* fields hold their values until the next pulse.
- No combinational path from mem_ready or mem_rdata to any output.

## Test plan
- ALU pass-through: add, rd=5, ALU_result=0x1234 -> next cycle MEM_valid=1, MEM_rd=5, MEM_ALU_result=0x1234, MEM_stall never high.
- Store byte (XLEN=32): SB at addr 0x103, rs2=0x000000AB -> mem_addr=0x100, mem_wstrb=4'b1000, mem_wdata=0xAB000000, mem_we=1. With mem_ready delayed 3 cycles, MEM_stall stays high 3 cycles and MEM_valid pulses once.
- Signed and unsigned loads: mem_rdata=0x80FF7F01.
  - LB at 0x02 -> MEM_load_data=0xFFFFFFFF.
  - LBU at 0x02 -> 0x000000FF.
  - LH at 0x02 -> 0xFFFF80FF.
  - LHU at 0x00 -> 0x00007F01.
- Misaligned: LW at 0x06 -> mem_req never asserts, next cycle MEM_valid=1, MEM_fault=1, MEM_regwrite=0.
- Reset mid-transaction: assert rst while BUSY with mem_req=1 -> mem_req drops without waiting for a clock. A later mem_ready produces no MEM_valid, and the next op issues normally.
- XLEN=64: LWU at 0x104, rdata=0xFEDCBA9876543210 -> 0x00000000FEDCBA98. LD at 0x104 -> MEM_fault=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: sub-word loads/stores with byte strobes, sign/zero extension,
// misalignment faults and a request/ready data-memory handshake that stalls upstream while busy.
module mem_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EX_MEM_valid,
  input  logic                EX_MEM_memread,
  input  logic                EX_MEM_memwrite,
  input  logic                EX_MEM_memtoreg,
  input  logic                EX_MEM_regwrite,
  input  logic [2:0]          EX_MEM_funct3,
  input  logic [4:0]          EX_MEM_rd,
  input  logic [XLEN-1:0]     EX_MEM_ALU_result,
  input  logic [XLEN-1:0]     EX_MEM_rs2_data,
  output logic                MEM_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic                mem_ready,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                MEM_valid,
  output logic                MEM_regwrite,
  output logic                MEM_memtoreg,
  output logic [4:0]          MEM_rd,
  output logic [XLEN-1:0]     MEM_ALU_result,
  output logic [XLEN-1:0]     MEM_load_data,
  output logic                MEM_fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_reg, state_next;

  // Latched request, held stable for the whole BUSY period
  logic              req_we_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic [XLEN-1:0]   req_wdata_reg;
  logic [NB-1:0]     req_wstrb_reg;
  logic [OFF_W-1:0]  req_off_reg;
  logic [2:0]        req_funct3_reg;

  // Writeback fields of the outstanding memory op, published only when it completes
  logic              pend_regwrite_reg;
  logic              pend_memtoreg_reg;
  logic [4:0]        pend_rd_reg;
  logic [XLEN-1:0]   pend_alu_reg;

  logic              mem_valid_reg;
  logic              mem_regwrite_reg;
  logic              mem_memtoreg_reg;
  logic [4:0]        mem_rd_reg;
  logic [XLEN-1:0]   mem_alu_reg;
  logic [XLEN-1:0]   mem_load_reg;
  logic              mem_fault_reg;

  logic [OFF_W-1:0]  off;
  logic [NB-1:0]     size_mask;
  logic              legal;
  logic              misaligned;
  logic              is_mem;
  logic              accept;
  logic              go_busy;
  logic              fault_now;

  assign off = EX_MEM_ALU_result[OFF_W-1:0];

  always_comb begin
    legal      = 1'b1;
    misaligned = 1'b0;
    size_mask  = '0;
    case (EX_MEM_funct3)
      3'b000, 3'b100: size_mask = NB'(8'h01);
      3'b001, 3'b101: begin
        size_mask  = NB'(8'h03);
        misaligned = off[0];
      end
      3'b010: begin
        size_mask  = NB'(8'h0F);
        misaligned = |off[1:0];
      end
      3'b110: begin
        size_mask  = NB'(8'h0F);
        misaligned = |off[1:0];
        legal      = (XLEN == 64);
      end
      3'b011: begin
        size_mask  = NB'(8'hFF);
        misaligned = |off;
        legal      = (XLEN == 64);
      end
      default: legal = 1'b0;
    endcase
  end

  assign is_mem    = EX_MEM_memread | EX_MEM_memwrite;
  assign accept    = (state_reg == IDLE) && EX_MEM_valid;
  assign go_busy   = accept && is_mem && legal && !misaligned;
  assign fault_now = accept && is_mem && (!legal || misaligned);

  // Load extraction from the registered request; result is registered, never driven straight out
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            sign_bit;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    shifted   = mem_rdata >> {req_off_reg, 3'b000};
    keep_mask = '1;
    sign_bit  = 1'b0;
    case (req_funct3_reg[1:0])
      2'b00: begin keep_mask = XLEN'(8'hFF);         sign_bit = shifted[7];  end
      2'b01: begin keep_mask = XLEN'(16'hFFFF);      sign_bit = shifted[15]; end
      2'b10: begin keep_mask = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin keep_mask = '1;                 sign_bit = 1'b0;        end
    endcase
    load_ext = (shifted & keep_mask) |
               ((!req_funct3_reg[2] && sign_bit) ? ~keep_mask : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go_busy)   state_next = BUSY;
      BUSY:    if (mem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    MEM_stall = (state_reg == BUSY);
    mem_req   = (state_reg == BUSY);
    mem_we    = (state_reg == BUSY) && req_we_reg;
    mem_addr  = (state_reg == BUSY) ? req_addr_reg  : '0;
    mem_wdata = (state_reg == BUSY) ? req_wdata_reg : '0;
    mem_wstrb = (state_reg == BUSY) ? req_wstrb_reg : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we_reg        <= 1'b0;
      req_addr_reg      <= '0;
      req_wdata_reg     <= '0;
      req_wstrb_reg     <= '0;
      req_off_reg       <= '0;
      req_funct3_reg    <= '0;
      pend_regwrite_reg <= 1'b0;
      pend_memtoreg_reg <= 1'b0;
      pend_rd_reg       <= '0;
      pend_alu_reg      <= '0;
      mem_valid_reg     <= 1'b0;
      mem_regwrite_reg  <= 1'b0;
      mem_memtoreg_reg  <= 1'b0;
      mem_rd_reg        <= '0;
      mem_alu_reg       <= '0;
      mem_load_reg      <= '0;
      mem_fault_reg     <= 1'b0;
    end else begin
      mem_valid_reg <= 1'b0;
      if (go_busy) begin
        req_we_reg        <= EX_MEM_memwrite;
        req_addr_reg      <= EX_MEM_ALU_result[ADDR_W-1:0] & ~ADDR_W'(NB - 1);
        req_wdata_reg     <= EX_MEM_rs2_data << {off, 3'b000};
        req_wstrb_reg     <= EX_MEM_memwrite ? (size_mask << off) : '0;
        req_off_reg       <= off;
        req_funct3_reg    <= EX_MEM_funct3;
        pend_regwrite_reg <= EX_MEM_regwrite;
        pend_memtoreg_reg <= EX_MEM_memtoreg;
        pend_rd_reg       <= EX_MEM_rd;
        pend_alu_reg      <= EX_MEM_ALU_result;
      end else if (accept) begin
        mem_valid_reg    <= 1'b1;
        mem_regwrite_reg <= EX_MEM_regwrite && !fault_now;
        mem_memtoreg_reg <= EX_MEM_memtoreg;
        mem_rd_reg       <= EX_MEM_rd;
        mem_alu_reg      <= EX_MEM_ALU_result;
        mem_load_reg     <= '0;
        mem_fault_reg    <= fault_now;
      end
      if (state_reg == BUSY && mem_ready) begin
        mem_valid_reg    <= 1'b1;
        mem_regwrite_reg <= pend_regwrite_reg;
        mem_memtoreg_reg <= pend_memtoreg_reg;
        mem_rd_reg       <= pend_rd_reg;
        mem_alu_reg      <= pend_alu_reg;
        mem_load_reg     <= req_we_reg ? '0 : load_ext;
        mem_fault_reg    <= 1'b0;
      end
    end
  end

  assign MEM_valid      = mem_valid_reg;
  assign MEM_regwrite   = mem_regwrite_reg;
  assign MEM_memtoreg   = mem_memtoreg_reg;
  assign MEM_rd         = mem_rd_reg;
  assign MEM_ALU_result = mem_alu_reg;
  assign MEM_load_data  = mem_load_reg;
  assign MEM_fault      = mem_fault_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit and a 64-bit instance share stimulus,
// expected writebacks go through a scoreboard queue and are checked when MEM_valid pulses.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v32, v64, sel64;
  logic        memread, memwrite, memtoreg, regwrite;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [63:0] alu, rs2, rdata;
  logic        rdy32, rdy64;

  logic        stall_a, req_a, we_a, mv_a, mrw_a, mtr_a, mf_a;
  logic [31:0] addr_a, wdata_a, malu_a, mld_a;
  logic [3:0]  wstrb_a;
  logic [4:0]  mrd_a;

  logic        stall_b, req_b, we_b, mv_b, mrw_b, mtr_b, mf_b;
  logic [31:0] addr_b;
  logic [63:0] wdata_b, malu_b, mld_b;
  logic [7:0]  wstrb_b;
  logic [4:0]  mrd_b;

  mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .EX_MEM_valid(v32),
    .EX_MEM_memread(memread), .EX_MEM_memwrite(memwrite),
    .EX_MEM_memtoreg(memtoreg), .EX_MEM_regwrite(regwrite),
    .EX_MEM_funct3(funct3), .EX_MEM_rd(rd),
    .EX_MEM_ALU_result(alu[31:0]), .EX_MEM_rs2_data(rs2[31:0]),
    .MEM_stall(stall_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_wstrb(wstrb_a), .mem_ready(rdy32), .mem_rdata(rdata[31:0]),
    .MEM_valid(mv_a), .MEM_regwrite(mrw_a), .MEM_memtoreg(mtr_a), .MEM_rd(mrd_a),
    .MEM_ALU_result(malu_a), .MEM_load_data(mld_a), .MEM_fault(mf_a)
  );

  mem_access_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .EX_MEM_valid(v64),
    .EX_MEM_memread(memread), .EX_MEM_memwrite(memwrite),
    .EX_MEM_memtoreg(memtoreg), .EX_MEM_regwrite(regwrite),
    .EX_MEM_funct3(funct3), .EX_MEM_rd(rd),
    .EX_MEM_ALU_result(alu), .EX_MEM_rs2_data(rs2),
    .MEM_stall(stall_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_wstrb(wstrb_b), .mem_ready(rdy64), .mem_rdata(rdata),
    .MEM_valid(mv_b), .MEM_regwrite(mrw_b), .MEM_memtoreg(mtr_b), .MEM_rd(mrd_b),
    .MEM_ALU_result(malu_b), .MEM_load_data(mld_b), .MEM_fault(mf_b)
  );

  logic        o_stall, o_req, o_we, o_valid, o_regwrite, o_memtoreg, o_fault;
  logic [63:0] o_addr, o_wdata, o_alu, o_ld;
  logic [7:0]  o_wstrb;
  logic [4:0]  o_rd;

  assign o_stall    = sel64 ? stall_b : stall_a;
  assign o_req      = sel64 ? req_b   : req_a;
  assign o_we       = sel64 ? we_b    : we_a;
  assign o_addr     = sel64 ? {32'b0, addr_b} : {32'b0, addr_a};
  assign o_wdata    = sel64 ? wdata_b : {32'b0, wdata_a};
  assign o_wstrb    = sel64 ? wstrb_b : {4'b0, wstrb_a};
  assign o_valid    = sel64 ? mv_b    : mv_a;
  assign o_regwrite = sel64 ? mrw_b   : mrw_a;
  assign o_memtoreg = sel64 ? mtr_b   : mtr_a;
  assign o_rd       = sel64 ? mrd_b   : mrd_a;
  assign o_alu      = sel64 ? malu_b  : {32'b0, malu_a};
  assign o_ld       = sel64 ? mld_b   : {32'b0, mld_a};
  assign o_fault    = sel64 ? mf_b    : mf_a;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] ld;
    logic        fault;
    logic        regwrite;
    logic        memtoreg;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input string what, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s got=%h exp=%h", tag, what, got, exp);
    end
  endtask

  // Drive one instruction for a single cycle (called at a negedge) and record its expected writeback
  task automatic issue(input bit s64, input logic mr, input logic mw, input logic mtr, input logic rw,
                       input logic [2:0] f3, input logic [4:0] r, input logic [63:0] a,
                       input logic [63:0] d, input logic [63:0] exp_ld, input logic exp_fault);
    wb_t e;
    sel64 = s64; memread = mr; memwrite = mw; memtoreg = mtr; regwrite = rw;
    funct3 = f3; rd = r; alu = a; rs2 = d;
    if (s64) v64 = 1'b1; else v32 = 1'b1;
    e.rd = r; e.alu = s64 ? a : {32'b0, a[31:0]}; e.ld = exp_ld;
    e.fault = exp_fault; e.regwrite = rw & ~exp_fault; e.memtoreg = mtr;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
  endtask

  // Hold off mem_ready for k-1 busy cycles, answer in the k-th
  task automatic respond(input int k, input logic [63:0] data, input string tag);
    for (int i = 1; i <= k; i++) begin
      chk(tag, "stall", {63'b0, o_stall}, 64'd1);
      chk(tag, "req", {63'b0, o_req}, 64'd1);
      if (i == k) begin
        rdata = data;
        if (sel64) rdy64 = 1'b1; else rdy32 = 1'b1;
      end
      @(negedge clk);
    end
    rdy32 = 1'b0; rdy64 = 1'b0;
    chk(tag, "stall_done", {63'b0, o_stall}, 64'd0);
  endtask

  task automatic expect_wb(input string tag);
    wb_t e;
    chk(tag, "valid", {63'b0, o_valid}, 64'd1);
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s.scoreboard got=empty exp=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "rd", {59'b0, o_rd}, {59'b0, e.rd});
      chk(tag, "alu", o_alu, e.alu);
      chk(tag, "load", o_ld, e.ld);
      chk(tag, "fault", {63'b0, o_fault}, {63'b0, e.fault});
      chk(tag, "regwrite", {63'b0, o_regwrite}, {63'b0, e.regwrite});
      chk(tag, "memtoreg", {63'b0, o_memtoreg}, {63'b0, e.memtoreg});
    end
    @(negedge clk);
    chk(tag, "pulse", {63'b0, o_valid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; v32 = 0; v64 = 0; sel64 = 0;
    memread = 0; memwrite = 0; memtoreg = 0; regwrite = 0;
    funct3 = 0; rd = 0; alu = 0; rs2 = 0; rdata = 0; rdy32 = 0; rdy64 = 0;
    repeat (2) @(negedge clk);
    chk("reset32", "req", {63'b0, o_req}, 64'd0);
    chk("reset32", "stall", {63'b0, o_stall}, 64'd0);
    chk("reset32", "valid", {63'b0, o_valid}, 64'd0);
    chk("reset32", "wstrb", {56'b0, o_wstrb}, 64'd0);
    sel64 = 1;
    chk("reset64", "req", {63'b0, o_req}, 64'd0);
    chk("reset64", "alu", o_alu, 64'd0);
    sel64 = 0;
    rst = 1'b0;
    @(negedge clk);

    // ALU pass-through
    issue(0, 0, 0, 0, 1, 3'b000, 5'd5, 64'h1234, 64'h0, 64'h0, 0);
    chk("alu", "stall", {63'b0, o_stall}, 64'd0);
    chk("alu", "req", {63'b0, o_req}, 64'd0);
    expect_wb("alu");

    // SB at 0x103, ready after 3 busy cycles
    issue(0, 0, 1, 0, 0, 3'b000, 5'd0, 64'h103, 64'hAB, 64'h0, 0);
    chk("sb", "addr", o_addr, 64'h100);
    chk("sb", "wstrb", {56'b0, o_wstrb}, 64'h8);
    chk("sb", "wdata", o_wdata, 64'hAB00_0000);
    chk("sb", "we", {63'b0, o_we}, 64'd1);
    respond(3, 64'h0, "sb");
    expect_wb("sb");

    // SH at 0x2
    issue(0, 0, 1, 0, 0, 3'b001, 5'd0, 64'h2, 64'hBEEF, 64'h0, 0);
    chk("sh", "wstrb", {56'b0, o_wstrb}, 64'hC);
    chk("sh", "wdata", o_wdata, 64'hBEEF_0000);
    respond(1, 64'h0, "sh");
    expect_wb("sh");

    // Sign/zero-extended loads from 0x80FF7F01
    issue(0, 1, 0, 1, 1, 3'b000, 5'd10, 64'h2, 64'h0, 64'hFFFF_FFFF, 0);
    chk("lb", "we", {63'b0, o_we}, 64'd0);
    chk("lb", "wstrb", {56'b0, o_wstrb}, 64'h0);
    chk("lb", "addr", o_addr, 64'h0);
    respond(1, 64'h80FF_7F01, "lb");
    expect_wb("lb");
    issue(0, 1, 0, 1, 1, 3'b100, 5'd11, 64'h2, 64'h0, 64'h0000_00FF, 0);
    respond(2, 64'h80FF_7F01, "lbu");
    expect_wb("lbu");
    issue(0, 1, 0, 1, 1, 3'b001, 5'd12, 64'h2, 64'h0, 64'hFFFF_80FF, 0);
    respond(1, 64'h80FF_7F01, "lh");
    expect_wb("lh");
    issue(0, 1, 0, 1, 1, 3'b101, 5'd13, 64'h0, 64'h0, 64'h0000_7F01, 0);
    respond(1, 64'h80FF_7F01, "lhu");
    expect_wb("lhu");
    issue(0, 1, 0, 1, 1, 3'b010, 5'd14, 64'h20, 64'h0, 64'h80FF_7F01, 0);
    chk("lw", "addr", o_addr, 64'h20);
    respond(1, 64'h80FF_7F01, "lw");
    expect_wb("lw");

    // Faults: misaligned word, LD and LWU on a 32-bit datapath
    issue(0, 1, 0, 1, 1, 3'b010, 5'd15, 64'h6, 64'h0, 64'h0, 1);
    chk("lw_mis", "req", {63'b0, o_req}, 64'd0);
    expect_wb("lw_mis");
    issue(0, 1, 0, 1, 1, 3'b011, 5'd16, 64'h8, 64'h0, 64'h0, 1);
    chk("ld32", "req", {63'b0, o_req}, 64'd0);
    expect_wb("ld32");
    issue(0, 1, 0, 1, 1, 3'b110, 5'd17, 64'h8, 64'h0, 64'h0, 1);
    expect_wb("lwu32");

    // Reset while busy: request drops immediately, late ready is ignored
    issue(0, 1, 0, 1, 1, 3'b010, 5'd7, 64'h10, 64'h0, 64'h0, 0);
    chk("rst_busy", "req_before", {63'b0, o_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", "req_after", {63'b0, o_req}, 64'd0);
    chk("rst_busy", "stall_after", {63'b0, o_stall}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    rdata = 64'h1234_5678;
    rdy32 = 1'b1;
    @(negedge clk);
    rdy32 = 1'b0;
    chk("rst_busy", "late_ready_valid", {63'b0, o_valid}, 64'd0);
    issue(0, 1, 0, 1, 1, 3'b100, 5'd8, 64'h3, 64'h0, 64'h0000_0080, 0);
    respond(2, 64'h80FF_7F01, "post_rst");
    expect_wb("post_rst");

    // 64-bit datapath
    issue(1, 1, 0, 1, 1, 3'b110, 5'd20, 64'h104, 64'h0, 64'h0000_0000_FEDC_BA98, 0);
    chk("lwu64", "addr", o_addr, 64'h100);
    respond(2, 64'hFEDC_BA98_7654_3210, "lwu64");
    expect_wb("lwu64");
    issue(1, 1, 0, 1, 1, 3'b010, 5'd21, 64'h104, 64'h0, 64'hFFFF_FFFF_FEDC_BA98, 0);
    respond(1, 64'hFEDC_BA98_7654_3210, "lw64");
    expect_wb("lw64");
    issue(1, 1, 0, 1, 1, 3'b011, 5'd22, 64'h104, 64'h0, 64'h0, 1);
    chk("ld64_mis", "req", {63'b0, o_req}, 64'd0);
    expect_wb("ld64_mis");
    issue(1, 0, 1, 0, 0, 3'b011, 5'd0, 64'h108, 64'h1122_3344_5566_7788, 64'h0, 0);
    chk("sd64", "wstrb", {56'b0, o_wstrb}, 64'hFF);
    chk("sd64", "wdata", o_wdata, 64'h1122_3344_5566_7788);
    chk("sd64", "addr", o_addr, 64'h108);
    respond(1, 64'h0, "sd64");
    expect_wb("sd64");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
